alu_wb: RTL and testbench

ALU_WB -- requirements
Module: alu_wb

---
 rtl/alu_wb_if.sv | 32 +++
 rtl/alu_wb.sv | 155 +++++++++++++++
 tb/tb_alu_wb.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_wb_if.sv
// Handshake bundle between the ALU, the write-back stage, the register file and the control unit.
interface alu_wb_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_res;
  logic        in_err;
  logic [4:0]  in_rd;
  logic [4:0]  in_op;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        wr_ready;
  logic        exc_valid;
  logic [4:0]  exc_op;
  logic        exc_clear;
  logic        halted;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_data;

  modport slave (
    input  in_valid, in_res, in_err, in_rd, in_op, wr_ready, exc_clear,
    output in_ready, wr_en, wr_addr, wr_data, exc_valid, exc_op, halted,
           fwd_valid, fwd_rd, fwd_data
  );

  modport master (
    output in_valid, in_res, in_err, in_rd, in_op, wr_ready, exc_clear,
    input  in_ready, wr_en, wr_addr, wr_data, exc_valid, exc_op, halted,
           fwd_valid, fwd_rd, fwd_data
  );
endinterface

// File: rtl/alu_wb.sv
// ALU write-back stage: 2-entry result FIFO, register-file write port, exception halt.
// Define FWD_BYPASS_EN to build the youngest-entry operand bypass; otherwise fwd_* are tied to 0.
module alu_wb (
  input  logic     clk,
  input  logic     rst_n,
  alu_wb_if.slave  bus
);
  localparam int DATA_W = 64;

  typedef enum logic {RUN, HALT} state_t;

  state_t              state_q, state_d;
  logic [1:0]          count_q, count_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                rdy_en_q, rdy_en_d;
  logic                exc_valid_q, exc_valid_d;
  logic [4:0]          exc_op_q, exc_op_d;

  logic [DATA_W-1:0]   res_q [2];
  logic [DATA_W-1:0]   res_d [2];
  logic                err_q [2];
  logic                err_d [2];
  logic [4:0]          rd_q  [2];
  logic [4:0]          rd_d  [2];
  logic [4:0]          op_q  [2];
  logic [4:0]          op_d  [2];

  logic                in_ready_w;
  logic                push;
  logic                pop;
  logic                wr_en_w;
  logic [DATA_W-1:0]   head_res;
  logic                head_err;
  logic [4:0]          head_rd;
  logic [4:0]          head_op;

  // rdy_en_q keeps in_ready low while reset is asserted and rises on the first edge after release
  assign in_ready_w = rdy_en_q && (state_q == RUN) && (count_q != 2'd2);
  assign push       = bus.in_valid && in_ready_w;

  assign head_res = res_q[rd_ptr_q];
  assign head_err = err_q[rd_ptr_q];
  assign head_rd  = rd_q[rd_ptr_q];
  assign head_op  = op_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rdy_en_d    = 1'b1;
    exc_valid_d = 1'b0;
    exc_op_d    = exc_op_q;
    res_d       = res_q;
    err_d       = err_q;
    rd_d        = rd_q;
    op_d        = op_q;
    pop         = 1'b0;
    wr_en_w     = 1'b0;

    case (state_q)
      RUN: begin
        if (count_q != 2'd0) begin
          if (head_err) begin
            pop         = 1'b1;
            state_d     = HALT;
            exc_valid_d = 1'b1;
            exc_op_d    = head_op;
          end else if (head_rd == 5'd0) begin
            pop = 1'b1;
          end else begin
            wr_en_w = 1'b1;
            pop     = bus.wr_ready;
          end
        end
      end
      HALT: begin
        if (bus.exc_clear) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (push) begin
      res_d[wr_ptr_q] = bus.in_res;
      err_d[wr_ptr_q] = bus.in_err;
      rd_d[wr_ptr_q]  = bus.in_rd;
      op_d[wr_ptr_q]  = bus.in_op;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push) - 2'(pop);

    // Leaving HALT squashes every younger result still queued behind the faulting one
    if ((state_q == HALT) && bus.exc_clear) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      rdy_en_q    <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_op_q    <= 5'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rdy_en_q    <= rdy_en_d;
      exc_valid_q <= exc_valid_d;
      exc_op_q    <= exc_op_d;
    end
  end

  // Payload storage needs no reset: it is only observed through count_q-qualified outputs
  always_ff @(posedge clk) begin
    res_q <= res_d;
    err_q <= err_d;
    rd_q  <= rd_d;
    op_q  <= op_d;
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.wr_en     = wr_en_w;
  assign bus.wr_addr   = wr_en_w ? head_rd  : 5'd0;
  assign bus.wr_data   = wr_en_w ? head_res : '0;
  assign bus.exc_valid = exc_valid_q;
  assign bus.exc_op    = exc_op_q;
  assign bus.halted    = (state_q == HALT);

`ifdef FWD_BYPASS_EN
  logic fwd_v;
  assign fwd_v = (state_q == RUN) && (count_q != 2'd0) &&
                 !err_q[~wr_ptr_q] && (rd_q[~wr_ptr_q] != 5'd0);
  assign bus.fwd_valid = fwd_v;
  assign bus.fwd_rd    = fwd_v ? rd_q[~wr_ptr_q]  : 5'd0;
  assign bus.fwd_data  = fwd_v ? res_q[~wr_ptr_q] : '0;
`else
  assign bus.fwd_valid = 1'b0;
  assign bus.fwd_rd    = 5'd0;
  assign bus.fwd_data  = '0;
`endif

endmodule

// File: tb/tb_alu_wb.sv
// Self-checking bench for alu_wb: directed vector table, hand sequences, random vs queue model.
module tb_alu_wb;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_wb_if bus ();

  alu_wb u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [63:0] res;
    logic        err;
    logic [4:0]  rd;
    logic [4:0]  op;
    logic        wrr;
    logic        clr;
    logic        e_rdy;
    logic        e_wen;
    logic [4:0]  e_addr;
    logic [63:0] e_data;
    logic        e_exc;
    logic [4:0]  e_eop;
    logic        e_halt;
  } row_t;

  typedef struct {
    logic [63:0] res;
    logic        err;
    logic [4:0]  rd;
    logic [4:0]  op;
  } ent_t;

  row_t tbl [17];
  ent_t q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [63:0] res, input logic err,
                       input logic [4:0] rd, input logic [4:0] op,
                       input logic wrr, input logic clr);
    bus.in_valid  = vld;
    bus.in_res    = res;
    bus.in_err    = err;
    bus.in_rd     = rd;
    bus.in_op     = op;
    bus.wr_ready  = wrr;
    bus.exc_clear = clr;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic        m_halt, n_halt, m_pulse, n_pulse;
    logic [4:0]  m_eop;
    logic        e_rdy, e_wen;
    logic        r_vld, r_err, r_wrr, r_clr;
    logic [63:0] r_res;
    logic [4:0]  r_rd, r_op;
    ent_t        e;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);

    tbl[0]  = '{'1, 64'h5,    '0, 5'd3, 5'd1,  '1, '0, '1, '0, 5'd0, 64'h0,  '0, 5'd0, '0};
    tbl[1]  = '{'0, 64'h0,    '0, 5'd0, 5'd0,  '1, '0, '1, '1, 5'd3, 64'h5,  '0, 5'd0, '0};
    tbl[2]  = '{'1, 64'hA1,   '0, 5'd1, 5'd2,  '0, '0, '1, '0, 5'd0, 64'h0,  '0, 5'd0, '0};
    tbl[3]  = '{'1, 64'hB2,   '0, 5'd2, 5'd2,  '0, '0, '1, '1, 5'd1, 64'hA1, '0, 5'd0, '0};
    tbl[4]  = '{'1, 64'hC5,   '0, 5'd5, 5'd2,  '0, '0, '0, '1, 5'd1, 64'hA1, '0, 5'd0, '0};
    tbl[5]  = '{'0, 64'h0,    '0, 5'd0, 5'd0,  '1, '0, '0, '1, 5'd1, 64'hA1, '0, 5'd0, '0};
    tbl[6]  = '{'0, 64'h0,    '0, 5'd0, 5'd0,  '1, '0, '1, '1, 5'd2, 64'hB2, '0, 5'd0, '0};
    tbl[7]  = '{'1, 64'hFFFF, '0, 5'd0, 5'd3,  '0, '0, '1, '0, 5'd0, 64'h0,  '0, 5'd0, '0};
    tbl[8]  = '{'0, 64'h0,    '0, 5'd0, 5'd0,  '0, '0, '1, '0, 5'd0, 64'h0,  '0, 5'd0, '0};
    tbl[9]  = '{'1, 64'h77,   '1, 5'd6, 5'h05, '1, '0, '1, '0, 5'd0, 64'h0,  '0, 5'd0, '0};
    tbl[10] = '{'1, 64'h44,   '0, 5'd4, 5'd2,  '1, '0, '1, '0, 5'd0, 64'h0,  '0, 5'd0, '0};
    tbl[11] = '{'0, 64'h0,    '0, 5'd0, 5'd0,  '1, '0, '0, '0, 5'd0, 64'h0,  '1, 5'd5, '1};
    tbl[12] = '{'0, 64'h0,    '0, 5'd0, 5'd0,  '1, '1, '0, '0, 5'd0, 64'h0,  '0, 5'd5, '1};
    tbl[13] = '{'0, 64'h0,    '0, 5'd0, 5'd0,  '1, '1, '1, '0, 5'd0, 64'h0,  '0, 5'd5, '0};
    tbl[14] = '{'1, 64'h88,   '0, 5'd8, 5'd1,  '1, '0, '1, '0, 5'd0, 64'h0,  '0, 5'd5, '0};
    tbl[15] = '{'0, 64'h0,    '0, 5'd0, 5'd0,  '1, '0, '1, '1, 5'd8, 64'h88, '0, 5'd5, '0};
    tbl[16] = '{'0, 64'h0,    '0, 5'd0, 5'd0,  '1, '0, '1, '0, 5'd0, 64'h0,  '0, 5'd5, '0};

    // Reset values while asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
    chk("rst_wr_en",    64'(bus.wr_en),    64'h0);
    chk("rst_halted",   64'(bus.halted),   64'h0);
    chk("rst_exc",      64'(bus.exc_valid), 64'h0);
    chk("rst_fwd",      64'(bus.fwd_valid), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("t%0d_in_ready", i), 64'(bus.in_ready),  64'(tbl[i].e_rdy));
      chk($sformatf("t%0d_wr_en", i),    64'(bus.wr_en),     64'(tbl[i].e_wen));
      if (tbl[i].e_wen) begin
        chk($sformatf("t%0d_wr_addr", i), 64'(bus.wr_addr), 64'(tbl[i].e_addr));
        chk($sformatf("t%0d_wr_data", i), bus.wr_data,      tbl[i].e_data);
      end
      chk($sformatf("t%0d_exc_valid", i), 64'(bus.exc_valid), 64'(tbl[i].e_exc));
      chk($sformatf("t%0d_exc_op", i),    64'(bus.exc_op),    64'(tbl[i].e_eop));
      chk($sformatf("t%0d_halted", i),    64'(bus.halted),    64'(tbl[i].e_halt));
`ifndef FWD_BYPASS_EN
      chk($sformatf("t%0d_fwd_valid", i), 64'(bus.fwd_valid), 64'h0);
`endif
      drive(tbl[i].vld, tbl[i].res, tbl[i].err, tbl[i].rd, tbl[i].op, tbl[i].wrr, tbl[i].clr);
      step();
    end

    // Bypass: youngest of two stalled entries
    drive(1'b1, 64'h70, 1'b0, 5'd7, 5'd1, 1'b0, 1'b0);
    step();
`ifdef FWD_BYPASS_EN
    chk("fwd_rd_first", 64'(bus.fwd_rd), 64'd7);
`else
    chk("fwd_valid_off1", 64'(bus.fwd_valid), 64'h0);
`endif
    drive(1'b1, 64'h90, 1'b0, 5'd9, 5'd1, 1'b0, 1'b0);
    step();
    drive(1'b0, 64'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
`ifdef FWD_BYPASS_EN
    chk("fwd_valid_two", 64'(bus.fwd_valid), 64'h1);
    chk("fwd_rd_two",    64'(bus.fwd_rd),    64'd9);
    chk("fwd_data_two",  bus.fwd_data,       64'h90);
`else
    chk("fwd_valid_off2", 64'(bus.fwd_valid), 64'h0);
    chk("fwd_rd_off2",    64'(bus.fwd_rd),    64'h0);
`endif
    chk("fwd_head_addr", 64'(bus.wr_addr), 64'd7);
    bus.wr_ready = 1'b1;
    repeat (3) step();
    chk("fwd_drained", 64'(bus.fwd_valid), 64'h0);
    chk("fwd_drain_wen", 64'(bus.wr_en), 64'h0);

    // Reset while the head waits on wr_ready
    drive(1'b1, 64'h33, 1'b0, 5'd3, 5'd1, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk("mid_wr_en", 64'(bus.wr_en), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en",   64'(bus.wr_en),    64'h0);
    chk("mid_rst_wr_addr", 64'(bus.wr_addr),  64'h0);
    chk("mid_rst_wr_data", bus.wr_data,       64'h0);
    chk("mid_rst_ready",   64'(bus.in_ready), 64'h0);
    chk("mid_rst_exc_op",  64'(bus.exc_op),   64'h0);
    chk("mid_rst_halted",  64'(bus.halted),   64'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 64'(bus.in_ready), 64'h1);
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_wr_en", 64'(bus.wr_en),     64'h0);
      chk("post_rst_exc",   64'(bus.exc_valid), 64'h0);
      step();
    end

    // Random traffic against a queue model
    m_halt  = 1'b0;
    m_pulse = 1'b0;
    m_eop   = 5'd0;
    for (int c = 0; c < 600; c++) begin
      e_rdy = !m_halt && (q.size() < 2);
      e_wen = !m_halt && (q.size() > 0) && !q[0].err && (q[0].rd != 5'd0);
      chk("rnd_in_ready", 64'(bus.in_ready),  64'(e_rdy));
      chk("rnd_wr_en",    64'(bus.wr_en),     64'(e_wen));
      if (e_wen) begin
        chk("rnd_wr_addr", 64'(bus.wr_addr), 64'(q[0].rd));
        chk("rnd_wr_data", bus.wr_data,      q[0].res);
      end
      chk("rnd_exc_valid", 64'(bus.exc_valid), 64'(m_pulse));
      chk("rnd_exc_op",    64'(bus.exc_op),    64'(m_eop));
      chk("rnd_halted",    64'(bus.halted),    64'(m_halt));
`ifdef FWD_BYPASS_EN
      if (!m_halt && q.size() > 0 && !q[q.size()-1].err && q[q.size()-1].rd != 5'd0) begin
        chk("rnd_fwd_valid", 64'(bus.fwd_valid), 64'h1);
        chk("rnd_fwd_rd",    64'(bus.fwd_rd),    64'(q[q.size()-1].rd));
        chk("rnd_fwd_data",  bus.fwd_data,       q[q.size()-1].res);
      end else begin
        chk("rnd_fwd_valid", 64'(bus.fwd_valid), 64'h0);
      end
`else
      chk("rnd_fwd_valid", 64'(bus.fwd_valid), 64'h0);
`endif

      r_vld = 1'($urandom_range(0, 1));
      r_res = {32'($urandom), 32'($urandom)};
      r_err = ($urandom_range(0, 11) == 0);
      r_rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r_op  = 5'($urandom_range(0, 31));
      r_wrr = ($urandom_range(0, 3) != 0);
      r_clr = ($urandom_range(0, 2) == 0);
      drive(r_vld, r_res, r_err, r_rd, r_op, r_wrr, r_clr);

      n_halt  = m_halt;
      n_pulse = 1'b0;
      if (!m_halt && q.size() > 0) begin
        if (q[0].err) begin
          m_eop   = q[0].op;
          n_pulse = 1'b1;
          n_halt  = 1'b1;
          q.delete(0);
        end else if (q[0].rd == 5'd0 || r_wrr) begin
          q.delete(0);
        end
      end
      if (r_vld && e_rdy) begin
        e.res = r_res;
        e.err = r_err;
        e.rd  = r_rd;
        e.op  = r_op;
        q.push_back(e);
      end
      if (m_halt && r_clr) begin
        q.delete();
        n_halt = 1'b0;
      end
      m_halt  = n_halt;
      m_pulse = n_pulse;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
